// File: rtl/fc_pkg.sv
// Shared types and width helpers for the fully-connected activation loader.
// Holds the loader state encoding and the layer result width rule.
package fc_pkg;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        HOLD = 2'd1,
        OUT  = 2'd2
    } fc_state_e;

    // Two activations multiplied, summed over the full fan-in.
    function automatic int zw_width(input int width, input int fan_in);
        return width * 2 + $clog2(fan_in);
    endfunction

    function automatic int idx_width(input int fan_in);
        return (fan_in > 1) ? $clog2(fan_in) : 1;
    endfunction

endpackage

// File: rtl/fc_act_bank.sv
// Activation register bank: one write port plus a whole-bank synchronous clear.
// The bank is the only storage for x, so it is all-zero whenever a frame starts.
module fc_act_bank
    import fc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IN    = 128,
    localparam int IW   = idx_width(IN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [IW-1:0]    wr_idx_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] x_o [IN]
);

    logic [WIDTH-1:0] bank_q [IN];

    // Clear wins over a write so a frame never leaks into the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < IN; i++) begin
                bank_q[i] <= '0;
            end
        end else if (clr_i) begin
            for (int i = 0; i < IN; i++) begin
                bank_q[i] <= '0;
            end
        end else if (wr_en_i && (int'(wr_idx_i) < IN)) begin
            bank_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign x_o = bank_q;

endmodule

// File: rtl/fc_act_loader.sv
// Streams a frame of activations into a bank, holds it stable while the layer
// settles, then captures the layer result and offers it on a valid/ready port.
module fc_act_loader
    import fc_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int IN     = 128,
    parameter int SETTLE = 2,
    localparam int ZW    = zw_width(WIDTH, IN),
    localparam int IW    = idx_width(IN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic [WIDTH-1:0] x [IN],
    input  logic [ZW-1:0]    z_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ZW-1:0]    out_data,
    output logic             busy
);

    fc_state_e     state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [ZW-1:0] out_data_q, out_data_d;
    logic          wr_en;
    logic          clr;
    logic          beat;
    logic          frame_end;

    assign beat      = in_valid && (state_q == FILL);
    assign frame_end = in_last || (idx_q == IW'(IN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FILL;
            idx_q      <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
        end
    end

    // The settle counter starts at zero on the final beat, so the capture
    // edge lands exactly SETTLE edges after that beat.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        wr_en      = 1'b0;
        clr        = 1'b0;
        unique case (state_q)
            FILL: begin
                if (beat) begin
                    wr_en = 1'b1;
                    if (frame_end) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (cnt_q == 4'(SETTLE - 1)) begin
                    state_d    = OUT;
                    out_data_d = z_in;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = FILL;
                    idx_d   = '0;
                    clr     = 1'b1;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    fc_act_bank #(
        .WIDTH (WIDTH),
        .IN    (IN)
    ) u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_en),
        .wr_idx_i  (idx_q),
        .wr_data_i (in_data),
        .clr_i     (clr),
        .x_o       (x)
    );

    // in_ready stays low while reset is held so no beat is offered early.
    assign in_ready  = (state_q == FILL) && rst_n;
    assign out_valid = (state_q == OUT);
    assign out_data  = out_data_q;
    assign busy      = (state_q != FILL);

endmodule

// File: tb/tb_fc_act_loader.sv
// Randomized self-checking bench for fc_act_loader against a frame-level model.
// The model tracks expected bank contents per frame and expected result timing.
module tb_fc_act_loader;
    import fc_pkg::*;

    localparam int WIDTH  = 8;
    localparam int IN     = 128;
    localparam int SETTLE = 2;
    localparam int ZW     = zw_width(WIDTH, IN);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_last = 1'b0;
    logic [WIDTH-1:0] x [IN];
    logic [ZW-1:0]    z_in = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [ZW-1:0]    out_data;
    logic             busy;

    int               testCount = 0;
    int               failCount = 0;
    logic [WIDTH-1:0] modelX [IN];
    logic [ZW-1:0]    zExp;

    fc_act_loader #(
        .WIDTH  (WIDTH),
        .IN     (IN),
        .SETTLE (SETTLE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .x         (x),
        .z_in      (z_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearModel();
        for (int i = 0; i < IN; i++) modelX[i] = '0;
    endtask

    task automatic checkBank(input string tag);
        for (int i = 0; i < IN; i++) begin
            checkOutput($sformatf("%s x[%0d]", tag, i), 32'(x[i]), 32'(modelX[i]));
        end
    endtask

    // Drives n beats; mode 0: idx mod 256, 1: 0x11+idx, 2: random data.
    task automatic applyStimulus(input int n, input bit lastOnFinal, input int mode,
                                 input bit gaps);
        logic [WIDTH-1:0] d;
        for (int b = 0; b < n; b++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                in_valid = 1'b0;
                in_data  = WIDTH'($urandom);
                in_last  = 1'($urandom);
                tick();
            end
            case (mode)
                0:       d = WIDTH'(b % 256);
                1:       d = WIDTH'(8'h11 + b);
                default: d = WIDTH'($urandom);
            endcase
            if (b == 0 || b == n - 1) begin
                checkOutput($sformatf("in_ready beat %0d", b), 32'(in_ready), 32'd1);
            end
            in_valid  = 1'b1;
            in_data   = d;
            in_last   = lastOnFinal && (b == n - 1);
            modelX[b] = d;
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Walks HOLD and OUT with junk beats offered, checks the capture edge,
    // applies bp cycles of backpressure, then the handshake (or a reset in OUT).
    task automatic finishFrame(input int bp, input bit resetInOut);
        checkOutput("hold busy", 32'(busy), 32'd1);
        checkOutput("hold in_ready", 32'(in_ready), 32'd0);
        checkBank("hold");
        for (int c = 0; c < SETTLE - 1; c++) begin
            in_valid = 1'b1;
            in_last  = 1'($urandom);
            in_data  = WIDTH'($urandom);
            z_in     = ZW'($urandom);
            tick();
            checkOutput("hold out_valid", 32'(out_valid), 32'd0);
        end
        zExp = ZW'($urandom);
        z_in = zExp;
        tick();
        checkOutput("capture out_valid", 32'(out_valid), 32'd1);
        checkOutput("capture out_data", 32'(out_data), 32'(zExp));
        if (resetInOut) begin
            #2;
            rst_n = 1'b0;
            #1;
            clearModel();
            checkOutput("rst out out_valid", 32'(out_valid), 32'd0);
            checkOutput("rst out out_data", 32'(out_data), 32'd0);
            checkOutput("rst out busy", 32'(busy), 32'd0);
            checkBank("rst out");
            tick();
            rst_n    = 1'b1;
            in_valid = 1'b0;
            #1;
            checkOutput("rst out in_ready", 32'(in_ready), 32'd1);
            return;
        end
        for (int c = 0; c < bp; c++) begin
            out_ready = 1'b0;
            z_in      = ZW'($urandom);
            in_valid  = 1'b1;
            in_last   = 1'($urandom);
            in_data   = WIDTH'($urandom);
            tick();
            checkOutput("bp out_data", 32'(out_data), 32'(zExp));
            checkOutput("bp in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp out_valid", 32'(out_valid), 32'd1);
        end
        checkBank("out");
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        clearModel();
        checkOutput("done out_valid", 32'(out_valid), 32'd0);
        checkOutput("done in_ready", 32'(in_ready), 32'd1);
        checkOutput("done busy", 32'(busy), 32'd0);
        checkBank("done");
    endtask

    initial begin
        clearModel();
        #12;
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset out_data", 32'(out_data), 32'd0);
        checkBank("reset");
        tick();
        rst_n = 1'b1;
        #1;
        checkOutput("post reset in_ready", 32'(in_ready), 32'd1);

        // Full frame with last on the final beat.
        applyStimulus(IN, 1'b1, 0, 1'b0);
        finishFrame(3, 1'b0);

        // Short frame.
        applyStimulus(5, 1'b1, 1, 1'b0);
        finishFrame(1, 1'b0);

        // Missing last: the beat at IN-1 ends the frame on its own.
        applyStimulus(IN, 1'b0, 2, 1'b0);
        checkOutput("overflow in_ready", 32'(in_ready), 32'd0);
        finishFrame(10, 1'b0);

        // Randomized frames with idle gaps and random backpressure.
        for (int f = 0; f < 6; f++) begin
            int n;
            bit lf;
            n  = $urandom_range(1, IN);
            lf = (n < IN) ? 1'b1 : 1'($urandom);
            applyStimulus(n, lf, 2, 1'b1);
            finishFrame($urandom_range(0, 6), 1'b0);
        end

        // Reset mid-frame after beat 60, then a fresh frame from x[0].
        applyStimulus(61, 1'b0, 2, 1'b0);
        checkBank("mid frame");
        #2;
        rst_n = 1'b0;
        #1;
        clearModel();
        checkOutput("rst mid out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst mid busy", 32'(busy), 32'd0);
        checkBank("rst mid");
        tick();
        rst_n = 1'b1;
        #1;
        applyStimulus(7, 1'b1, 2, 1'b0);
        finishFrame(2, 1'b0);

        // Reset while a result is pending.
        applyStimulus(10, 1'b1, 2, 1'b0);
        finishFrame(0, 1'b1);
        applyStimulus(3, 1'b1, 1, 1'b0);
        finishFrame(1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/fc_act_loader.md
FC_ACT_LOADER -- requirements
Module: fc_act_loader

Interface
REQ-001 Parameter WIDTH, default 8: activation width in bits.
REQ-002 Parameter IN, default 128: activations per frame, i.e. the fan-in of the downstream fc layer.
REQ-003 Parameter SETTLE, default 2, range 1..15: cycles x is held stable before z_in is sampled.
REQ-004 Derived constant ZW = WIDTH*2+$clog2(IN): layer result width (23 at defaults).
REQ-005 Port clk, input, 1: single clock, rising edge.
REQ-006 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-007 Port in_valid, input, 1: in_data is valid this cycle.
REQ-008 Port in_ready, output, 1: loader accepts a beat this cycle.
REQ-009 Port in_data, input, WIDTH: one unsigned activation.
REQ-010 Port in_last, input, 1: marks the final beat of the frame.
REQ-011 Port x, output, unpacked array of IN elements of WIDTH bits: activation bank driven to the layer.
REQ-012 Port z_in, input, ZW: combinational result returned by the layer.
REQ-013 Port out_valid, output, 1: out_data holds a captured result.
REQ-014 Port out_ready, input, 1: downstream accepts out_data.
REQ-015 Port out_data, output, ZW: registered layer result.
REQ-016 Port busy, output, 1: high in every state except FILL.

Function
REQ-017 The loader SHALL implement three states: FILL, HOLD and OUT.
REQ-018 In FILL, in_ready SHALL be 1; in HOLD and OUT it SHALL be 0.
REQ-019 Beat rule: a beat SHALL be accepted when in_valid && in_ready.
REQ-020 Each accepted beat SHALL write in_data into x[idx] and increment idx, which starts at 0.
REQ-021 A frame SHALL end on an accepted beat with in_last=1, or on the beat written to idx=IN-1, whichever comes first; FILL then goes to HOLD.
REQ-022 Short frame: entries not written in that frame SHALL remain 0, because the bank is all-zero at frame start.
REQ-023 Overflow: the beat at IN-1 SHALL end the frame regardless of in_last; no beat SHALL be written beyond IN-1.
REQ-024 HOLD SHALL last exactly SETTLE cycles, with x unchanged throughout.
REQ-025 On the clock edge that ends the last HOLD cycle, out_data SHALL be loaded from z_in, the state SHALL become OUT, and out_valid SHALL rise.
REQ-026 Latency: with the final beat accepted at edge k, out_valid SHALL be 1 from edge k+SETTLE.
REQ-027 In OUT, out_valid SHALL stay 1 and out_data SHALL stay stable until out_valid && out_ready.
REQ-028 On the OUT handshake edge, all x SHALL clear to 0, idx SHALL clear to 0, out_valid SHALL fall, and the state SHALL return to FILL, so in_ready is 1 the next cycle.
REQ-029 in_valid and in_last SHALL be ignored outside FILL.
REQ-030 out_data SHALL be passed through without modification; the layer already applies ReLU, so no sign or saturation handling applies here.

Reset
REQ-031 While rst_n=0, the loader SHALL immediately set state=FILL, idx=0, all x=0, out_data=0, out_valid=0 and busy=0; in_ready becomes 1 once reset is released.
REQ-032 Reset asserted mid-frame or in OUT SHALL discard the partial frame and any pending result, and no result SHALL be emitted.

Structure
REQ-033 The state enum (FILL, HOLD, OUT) and the ZW width function SHALL live in a shared package, fc_pkg.
REQ-034 The 128-entry bank with write and clear SHALL be one sub-module, fc_act_bank; the FSM, idx counter and settle counter SHALL stay in fc_act_loader.

Verification
REQ-035 Full frame: 128 beats, data = idx mod 256, last on beat 127 -> x[i]=i, and out_valid rises exactly 2 cycles after the last beat with out_data = z_in at that edge.
REQ-036 Short frame: 5 beats 0x11..0x15, last on beat 4 -> x[0..4]=0x11..0x15, x[5..127]=0, and HOLD is entered.
REQ-037 Missing last: 128 beats with in_last=0 -> frame ends after beat 127 and in_ready=0 on the next cycle.
REQ-038 Backpressure: out_ready held 0 for 10 cycles with z_in toggling -> out_data unchanged and in_ready=0; out_ready=1 -> x all 0 and in_ready=1 the next cycle.
REQ-039 Beats presented during HOLD or OUT -> not accepted and x unchanged.
REQ-040 Reset after beat 60 -> all x=0, out_valid=0, and the next frame writes from x[0].
